// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
//   Load/store unit that sits between the core's data request port and a
//   single-ported synchronous data memory. It takes one request at a time and
//   turns byte/half/word (and, on 64-bit builds, doubleword) accesses into one
//   aligned memory cycle with byte enables. Load data is sign- or zero-extended.
//   Misaligned or illegal-size requests get an error response and never reach
//   memory. Read data is expected WAIT_STATES cycles after the read strobe.
//
// Ports
//   clk, reset          core clock, synchronous active-high reset
//   req_*               request handshake (valid/ready), op, size, sign, addr, wdata
//   resp_*              one-cycle response pulse with extended data and error flag
//   data_memory_*       aligned address, replicated store data, read data,
//                       read/write strobes and byte-lane enables
module data_mem_access_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_error,
    output logic [ADDR_W-1:0]   data_memory_a,
    output logic [DATA_W-1:0]   data_memory_out_v,
    input  logic [DATA_W-1:0]   data_memory_in_v,
    output logic                data_memory_read,
    output logic                data_memory_write,
    output logic [DATA_W/8-1:0] data_memory_be
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(WAIT_STATES + 1);

    typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP, S_ERR} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write;
    logic [1:0]       r_size;
    logic             r_signed;
    logic [OFF_W-1:0] r_off;

    logic             w_accept;
    logic             w_illegal;
    logic             w_misaligned;
    logic [OFF_W-1:0] w_off;

    // Byte-lane enables: the access-size mask moved up to the lane offset.
    function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] size,
                                                   input logic [OFF_W-1:0] off);
        logic [BE_W-1:0] m;
        case (size)
            2'b00:   m = BE_W'(1);
            2'b01:   m = BE_W'(3);
            2'b10:   m = BE_W'(15);
            default: m = '1;
        endcase
        return m << off;
    endfunction

    // Store data is copied into every lane so the memory picks it up wherever
    // the byte enables point.
    function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] wd,
                                                    input logic [1:0] size);
        logic [DATA_W-1:0] r;
        r = wd;
        case (size)
            2'b00:   for (int i = 0; i < BE_W; i++)     r[i*8  +: 8]  = wd[7:0];
            2'b01:   for (int i = 0; i < BE_W / 2; i++) r[i*16 +: 16] = wd[15:0];
            2'b10:   for (int i = 0; i < BE_W / 4; i++) r[i*32 +: 32] = wd[31:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Lane extraction and extension: the selected lane is pushed to the top of
    // the word and shifted back, arithmetically when sign extension is wanted.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] size,
                                                 input logic sgn,
                                                 input logic [OFF_W-1:0] off);
        logic        [DATA_W-1:0] lane;
        logic signed [DATA_W-1:0] t;
        int                       sh;
        lane = d >> {off, 3'b000};
        sh   = DATA_W - (8 << size);
        if (sh <= 0)
            return lane;
        t = $signed(lane << sh);
        if (sgn)
            return $unsigned(t >>> sh);
        return (lane << sh) >> sh;
    endfunction

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_off     = req_addr[OFF_W-1:0];
    assign w_illegal = (req_size == 2'b11) && (DATA_W == 32);

    always_comb begin
        w_misaligned = 1'b0;
        case (req_size)
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            2'b11:   w_misaligned = |req_addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end

    // Request capture: only the fields still needed after the accept cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write  <= req_write;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_off    <= w_off;
        end
    end

    // Control FSM; every output is registered and set on entry to its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_cnt             <= '0;
            resp_valid        <= 1'b0;
            resp_rdata        <= '0;
            resp_error        <= 1'b0;
            data_memory_a     <= '0;
            data_memory_out_v <= '0;
            data_memory_be    <= '0;
            data_memory_read  <= 1'b0;
            data_memory_write <= 1'b0;
        end else begin
            resp_valid        <= 1'b0;
            resp_error        <= 1'b0;
            data_memory_read  <= 1'b0;
            data_memory_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_illegal || w_misaligned) begin
                            r_state    <= S_ERR;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            r_state           <= S_ACCESS;
                            data_memory_a     <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            data_memory_be    <= lane_mask(req_size, w_off);
                            data_memory_out_v <= replicate(req_wdata, req_size);
                            data_memory_write <= req_write;
                            data_memory_read  <= !req_write;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_write) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_W'(WAIT_STATES - 1);
                    end
                end
                S_WAIT: begin
                    // Read data is valid in the cycle the counter sits at zero.
                    if (r_cnt == '0) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= extend(data_memory_in_v, r_size, r_signed, r_off);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                S_ERR:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Parametrised load/store unit between the CPU core's data-side request interface and a single-ported synchronous data memory.
- Accepts one request at a time via valid/ready and converts byte, halfword, word or (64-bit builds) doubleword accesses into aligned memory cycles with byte enables.
- Sign- or zero-extends load data, flags misaligned or illegal-size requests without touching memory, and tolerates a configurable number of memory read wait states.

Parameters:
ADDR_W, 32, byte-address width of request and memory address.
DATA_W, 32, data bus width; legal values 32 or 64.
WAIT_STATES, 1, cycles from the memory read strobe to valid read data; legal range 1..15.

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  CPU request valid
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when DATA_W=64)
req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend; ignored for stores
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  store data, right-justified
resp_valid  output  1  single-cycle response pulse
resp_rdata  output  DATA_W  extended load data; 0 for stores and errors
resp_error  output  1  qualified by resp_valid; misaligned or illegal size
data_memory_a  output  ADDR_W  aligned word address (low log2(DATA_W/8) bits zero)
data_memory_out_v  output  DATA_W  store data replicated across lanes
data_memory_in_v  input  DATA_W  memory read data
data_memory_read  output  1  read strobe
data_memory_write  output  1  write strobe
data_memory_be  output  DATA_W/8  byte-lane enables, bit i = byte i (little-endian)

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP, ERR. Reset forces IDLE and clears every registered output to 0: resp_valid, resp_rdata, resp_error, data_memory_a, out_v, be, read, write. req_ready = (state==IDLE), so it is 1 in the first cycle after reset deasserts.
- Accept: req_valid && req_ready at cycle 0 latches write, size, signed, addr and wdata. req_valid while not ready is ignored; nothing is queued.
- Legality check at accept:
  - ERR if size is 11 with DATA_W=32.
  - ERR if addr is not aligned to its size (half: addr[0]; word: addr[1:0]; dword: addr[2:0]).
  - Otherwise go to ACCESS.
- ERR (cycle 1): resp_valid=1, resp_error=1, resp_rdata=0, no memory strobe. Next state is IDLE.
- ACCESS (cycle 1): drive a, be and out_v.
  - be = size mask shifted left by the lane offset.
  - out_v = wdata low bits replicated to fill DATA_W.
  - Store: write=1 for exactly this cycle, then RESP; resp_valid appears in cycle 2.
  - Load: read=1 for exactly this cycle, then WAIT with the counter loaded with WAIT_STATES-1.
- WAIT: a and be held stable; the counter decrements each cycle.
  - When the counter reaches 0 in a cycle, data_memory_in_v is valid in that same cycle, i.e. cycle 1+WAIT_STATES.
  - In that cycle, extract the lane at the offset, extend per signed/size into resp_rdata, and go to RESP.
- RESP: resp_valid=1 and resp_error=0 for one cycle, then IDLE.
  - Load latency: resp_valid in cycle 2+WAIT_STATES.
  - Store latency: resp_valid in cycle 2.
  - A new request is accepted no earlier than the following cycle.
- resp_rdata holds its value until the next response or reset; resp_valid is never high for more than 1 cycle. Strobes: read and write are never both high, and each is high only in ACCESS.
- Doubleword with DATA_W=64: be all ones, no extension.
- Reset mid-transaction (any state): strobes and resp_valid are 0 on the next edge, no response is issued, and the unit is in IDLE.
- Counter width: $clog2(WAIT_STATES+1). Response pulses do not depend on an upstream ready; the CPU must always consume them.

Test Plan:
- Reset/idle (DATA_W=32, WAIT_STATES=2): hold reset 3 cycles with req_valid=1 -> all outputs 0; req_ready=1 in the first cycle after release; no strobe.
- Word store: addr 0x100, wdata 0xDEADBEEF, accepted cycle 0 -> cycle 1: a=0x100, write=1, be=1111, out_v=0xDEADBEEF; cycle 2: resp_valid=1, error=0, rdata=0; req_ready back to 1 in cycle 3.
- Half store: addr 0x102, wdata 0x0000ABCD -> out_v=0xABCDABCD, be=1100, a=0x100.
- Byte loads, memory returns 0x80FF1234 in cycle 3:
  - Signed, addr 0x103 -> read=1 only in cycle 1, be=1000; cycle 4: resp_valid=1, rdata=0xFFFFFF80.
  - Unsigned, same addr -> rdata=0x00000080.
  - Signed half, addr 0x100 -> rdata=0x00001234.
- Errors:
  - Half load at 0x101 -> cycle 1: resp_valid=1, resp_error=1, rdata=0; read/write never asserted.
  - req_size=11 with DATA_W=32 -> same error response.
- Reset mid-load: assert reset in cycle 2, the WAIT state of a word load -> next cycle read=0, resp_valid stays 0 through cycle 6, req_ready=1.
